game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Game-flow controller that sequences the dragon/robot/missile datapath. It runs the round state machine (idle, play, hit-freeze, over) and gates all object motion through a single `move_en`. It edge-detects the collision events, keeps the BCD score, lives and countdown timer, and sits between the keyboard/collision logic and the movers/renderer in the top level.

## Interface
Parameters:
- `TIME_LIMIT`, 60: round length in seconds, 1..99.
- `LIVES`, 3: lives loaded at round start, 1..3.
- `FREEZE_TICKS`, 2: seconds the movers are frozen after the robot is hit, 1..7.
- `WIN_SCORE`, 50: score that ends the round as a win, 1..999.

Ports:
- `clk` in 1: single system clock; every input is synchronous to it.
- `rst` in 1: asynchronous, active-low reset.
- `tick_1hz` in 1: one-`clk`-wide pulse, once per second.
- `start_key` in 1: level from keyboard decode, held for ≥1 cycle while the key is down.
- `hit_dragon` in 1: level; the missile overlaps the dragon (Event[1]).
- `hit_robot` in 1: level; the dragon overlaps the robot (Event[0]).
- `game_state` out 2: IDLE=0, PLAY=1, HIT=2, OVER=3.
- `move_en` out 1: movers may advance; high only in PLAY.
- `score_bcd` out 12: three BCD digits.
- `lives` out 2: remaining lives.
- `time_left` out 7: remaining seconds, binary.
- `win` out 1: valid in OVER; 1 means the round was won.

## Operation
- Edge detect on `start_key`, `hit_dragon` and `hit_robot`: one registered copy of each; an event is `x & ~x_q`. A held level counts once.
- IDLE:
  - `move_en`=0; score, lives and time keep their last values.
  - Start edge → PLAY. Load score=0, lives=`LIVES`, time_left=`TIME_LIMIT`, `win`=0.
- PLAY:
  - hit_dragon edge: score increments in BCD and saturates at 999.
  - hit_robot edge: lives decrements. If the result is 0 → OVER with win=0. Otherwise → HIT and load freeze_cnt=`FREEZE_TICKS`.
  - tick: time_left decrements. If the result is 0 → OVER with win=1 (survived).
  - If the incremented score is ≥ `WIN_SCORE` → OVER with win=1.
- Simultaneous events in the same cycle in PLAY:
  - All counters update independently.
  - Next-state priority: life lost to 0 (lose), then score reaches WIN_SCORE (win), then timeout (win), then HIT.
  - A hit that does not empty lives but coincides with a win condition goes to OVER with win=1, and lives still decrement.
- HIT:
  - `move_en`=0 and the timer is paused.
  - Each tick decrements freeze_cnt; when it reaches 0 → PLAY.
  - Collision edges in HIT are ignored.
- OVER:
  - `move_en`=0; all counters frozen.
  - Start edge → IDLE. The values stay visible until the next start.
- Start edges in PLAY and HIT are ignored.
- Asynchronous reset mid-round forces the IDLE reset values below immediately; no pending event survives.

## Timing
- All outputs are registered. Reset values: game_state=IDLE, move_en=0, score_bcd=0x000, lives=0, time_left=0, win=0. Edge-detect registers reset to 0.
- Latency: an input level change at edge N is detected at edge N+1, and outputs update at edge N+1 (visible after N+1).
- `move_en` is a registered decode of the next state, so it changes on the same edge as `game_state`.
- tick_1hz is not delayed: a tick at edge N updates time_left at edge N.
- BCD carry chain: 9→0 with carry ripples in the same cycle (099→100, 999 holds).
- Widths:
  - time_left 7 b, no wrap; a decrement at 0 is never issued.
  - lives 2 b, no wrap below 0.
  - freeze_cnt 3 b.

## Structure
- Shared package `game_pkg`:
  - `game_state_t` enum (IDLE/PLAY/HIT/OVER, 2-bit encoding as above).
  - Constants for the reset values.
- Sub-module `bcd_counter3`: 3-digit BCD incrementer with saturate-at-999 and synchronous clear, reusable for the score display.
- Top-level glue: instantiate with `hit_dragon`=Event[1], `hit_robot`=Event[0], and gate the movers' step enable with `move_en`.

## Test plan
- Reset then start pulse: state 0→1, lives=3, time_left=60, score=000, move_en=1 one cycle after the edge.
- hit_dragon held high for 10 cycles in PLAY: score 000→001 exactly once. Then 99 separate pulses from score 000: score=099, and the next pulse gives 100.
- hit_robot pulse with lives=3, FREEZE_TICKS=2: state=HIT, lives=2, move_en=0. Ticks in HIT leave time_left unchanged. Back to PLAY after the 2nd tick.
- Third robot hit, with simultaneous hit_dragon and tick in the same cycle: score+1, time_left−1, lives=0, state=OVER, win=0.
- 60 ticks with no hits: time_left=0, state=OVER, win=1. A start edge goes to IDLE, and a second start edge reloads score=000 and lives=3.
- Reset asserted in HIT with freeze_cnt=1: immediately state=IDLE, all outputs 0. After release, ticks cause no transition until a start edge.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : game_pkg
//  Purpose  : Shared round-state encoding, reset values and a BCD helper for
//             the game-flow controller and its score counter.
//  Revision : 1.0  initial release
// ============================================================================
package game_pkg;

   typedef enum logic [1:0] {
      GS_IDLE = 2'd0,
      GS_PLAY = 2'd1,
      GS_HIT  = 2'd2,
      GS_OVER = 2'd3
   } game_state_t;

   // Round-state codes as plain constants for the state register
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PLAY = 2'd1;
   localparam logic [1:0] ST_HIT  = 2'd2;
   localparam logic [1:0] ST_OVER = 2'd3;

   // Values forced by reset
   localparam logic [11:0] RST_SCORE  = 12'h000;
   localparam logic [1:0]  RST_LIVES  = 2'd0;
   localparam logic [6:0]  RST_TIME   = 7'd0;
   localparam logic [2:0]  RST_FREEZE = 3'd0;

   // Binary (0..999) to three packed BCD digits; used on constants only
   function automatic logic [11:0] to_bcd3(input int unsigned value);
      logic [11:0] res;
      res[11:8] = 4'((value / 100) % 10);
      res[7:4]  = 4'((value / 10) % 10);
      res[3:0]  = 4'(value % 10);
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_counter3.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_counter3
//  Purpose  : Three-digit BCD up-counter with synchronous clear and
//             saturation at 999. The next value is exported so the owner can
//             make decisions on the value that is about to be stored.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_counter3
   import game_pkg::*;
(
   input  logic        clk,
   input  logic        rst,        // asynchronous, active-low
   input  logic        clr,
   input  logic        inc,
   output logic [11:0] count,
   output logic [11:0] count_nxt
);

   // Next value: clear wins, otherwise ripple the digit carries in one cycle
   always_comb begin
      count_nxt = count;
      if (clr) begin
         count_nxt = 12'h000;
      end else if (inc && (count != 12'h999)) begin
         if (count[3:0] != 4'd9) begin
            count_nxt[3:0] = count[3:0] + 4'd1;
         end else begin
            count_nxt[3:0] = 4'd0;
            if (count[7:4] != 4'd9) begin
               count_nxt[7:4] = count[7:4] + 4'd1;
            end else begin
               count_nxt[7:4]  = 4'd0;
               count_nxt[11:8] = count[11:8] + 4'd1;
            end
         end
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= RST_SCORE;
      end else begin
         count <= count_nxt;
      end
   end

endmodule
`default_nettype wire

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : game_flow_ctrl
//  Purpose  : Round sequencer (idle/play/hit-freeze/over) for the dragon,
//             robot and missile datapath. Edge-detects the key and collision
//             levels, owns score, lives and countdown, and gates all object
//             motion through move_en.
//  Revision : 1.0  initial release
// ============================================================================
module game_flow_ctrl
   import game_pkg::*;
#(
   parameter int unsigned TIME_LIMIT   = 60,
   parameter int unsigned LIVES        = 3,
   parameter int unsigned FREEZE_TICKS = 2,
   parameter int unsigned WIN_SCORE    = 50
)(
   input  logic        clk,
   input  logic        rst,         // asynchronous, active-low
   input  logic        tick_1hz,
   input  logic        start_key,
   input  logic        hit_dragon,
   input  logic        hit_robot,
   output logic [1:0]  game_state,
   output logic        move_en,
   output logic [11:0] score_bcd,
   output logic [1:0]  lives,
   output logic [6:0]  time_left,
   output logic        win
);

   localparam logic [6:0]  TIME_INIT   = 7'(TIME_LIMIT);
   localparam logic [1:0]  LIVES_INIT  = 2'(LIVES);
   localparam logic [2:0]  FREEZE_INIT = 3'(FREEZE_TICKS);
   // BCD digits order the same way as the numbers, so a plain compare works
   localparam logic [11:0] WIN_BCD     = to_bcd3(WIN_SCORE);

   logic        start_q;
   logic        dragon_q;
   logic        robot_q;
   logic        start_ev;
   logic        dragon_ev;
   logic        robot_ev;

   logic [1:0]  state_nxt;
   logic [1:0]  lives_nxt;
   logic [6:0]  time_nxt;
   logic [2:0]  freeze_cnt;
   logic [2:0]  freeze_nxt;
   logic        win_nxt;

   logic        score_clr;
   logic        score_inc;
   logic [11:0] score_nxt;

   assign start_ev  = start_key  & ~start_q;
   assign dragon_ev = hit_dragon & ~dragon_q;
   assign robot_ev  = hit_robot  & ~robot_q;

   // Score is cleared on round start and counts missile hits only while playing
   assign score_clr = (game_state == ST_IDLE) && start_ev;
   assign score_inc = (game_state == ST_PLAY) && dragon_ev;

   bcd_counter3 u_score (
      .clk       (clk),
      .rst       (rst),
      .clr       (score_clr),
      .inc       (score_inc),
      .count     (score_bcd),
      .count_nxt (score_nxt)
   );

   // One registered copy of each level for rising-edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         start_q  <= 1'b0;
         dragon_q <= 1'b0;
         robot_q  <= 1'b0;
      end else begin
         start_q  <= start_key;
         dragon_q <= hit_dragon;
         robot_q  <= hit_robot;
      end
   end

   // Round state machine and counter updates; counters move independently,
   // the exit priority is lose, score win, timeout win, then freeze
   always_comb begin
      state_nxt  = game_state;
      lives_nxt  = lives;
      time_nxt   = time_left;
      freeze_nxt = freeze_cnt;
      win_nxt    = win;
      case (game_state)
         ST_IDLE: begin
            if (start_ev) begin
               state_nxt = ST_PLAY;
               lives_nxt = LIVES_INIT;
               time_nxt  = TIME_INIT;
               win_nxt   = 1'b0;
            end
         end
         ST_PLAY: begin
            if (robot_ev && (lives != 2'd0)) begin
               lives_nxt = lives - 2'd1;
            end
            if (tick_1hz && (time_left != 7'd0)) begin
               time_nxt = time_left - 7'd1;
            end
            if (robot_ev && (lives_nxt == 2'd0)) begin
               state_nxt = ST_OVER;
               win_nxt   = 1'b0;
            end else if (dragon_ev && (score_nxt >= WIN_BCD)) begin
               state_nxt = ST_OVER;
               win_nxt   = 1'b1;
            end else if (tick_1hz && (time_nxt == 7'd0)) begin
               state_nxt = ST_OVER;
               win_nxt   = 1'b1;
            end else if (robot_ev) begin
               state_nxt  = ST_HIT;
               freeze_nxt = FREEZE_INIT;
            end
         end
         ST_HIT: begin
            if (tick_1hz) begin
               if (freeze_cnt > 3'd1) begin
                  freeze_nxt = freeze_cnt - 3'd1;
               end else begin
                  freeze_nxt = 3'd0;
                  state_nxt  = ST_PLAY;
               end
            end
         end
         default: begin
            if (start_ev) begin
               state_nxt = ST_IDLE;
            end
         end
      endcase
   end

   // Registered outputs; move_en decodes the next state so it tracks game_state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         game_state <= ST_IDLE;
         move_en    <= 1'b0;
         lives      <= RST_LIVES;
         time_left  <= RST_TIME;
         freeze_cnt <= RST_FREEZE;
         win        <= 1'b0;
      end else begin
         game_state <= state_nxt;
         move_en    <= (state_nxt == ST_PLAY);
         lives      <= lives_nxt;
         time_left  <= time_nxt;
         freeze_cnt <= freeze_nxt;
         win        <= win_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_flow_ctrl
//  Purpose  : Directed self-checking bench for game_flow_ctrl. WIN_SCORE is
//             raised to 200 so the 099->100 carry is reachable in play.
//  Revision : 1.0  initial release
// ============================================================================
module tb_game_flow_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        tick_1hz = 1'b0;
   logic        start_key = 1'b0;
   logic        hit_dragon = 1'b0;
   logic        hit_robot = 1'b0;
   logic [1:0]  game_state;
   logic        move_en;
   logic [11:0] score_bcd;
   logic [1:0]  lives;
   logic [6:0]  time_left;
   logic        win;

   int tests = 0;
   int fails = 0;

   game_flow_ctrl #(
      .TIME_LIMIT   (60),
      .LIVES        (3),
      .FREEZE_TICKS (2),
      .WIN_SCORE    (200)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tick_1hz   (tick_1hz),
      .start_key  (start_key),
      .hit_dragon (hit_dragon),
      .hit_robot  (hit_robot),
      .game_state (game_state),
      .move_en    (move_en),
      .score_bcd  (score_bcd),
      .lives      (lives),
      .time_left  (time_left),
      .win        (win)
   );

   always #5 clk = ~clk;

   // advance n clock edges and settle 1 time unit past the last one
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start_key = 1'b1; cyc(1); start_key = 1'b0; cyc(1);
   endtask

   task automatic pulse_dragon();
      hit_dragon = 1'b1; cyc(1); hit_dragon = 1'b0; cyc(1);
   endtask

   task automatic pulse_tick();
      tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0; cyc(1);
   endtask

   task automatic test_reset();
      cyc(3);
      tests++; if (game_state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", game_state); end
      tests++; if (move_en !== 1'b0) begin fails++; $display("FAIL reset_move_en got %b exp 0", move_en); end
      tests++; if ({score_bcd, lives, time_left, win} !== 22'd0) begin fails++; $display("FAIL reset_counters score=%h lives=%0d time=%0d win=%b exp all 0", score_bcd, lives, time_left, win); end
      rst = 1'b1;
      cyc(2);
      tests++; if (game_state !== 2'd0) begin fails++; $display("FAIL idle_after_release got %0d exp 0", game_state); end
   endtask

   task automatic test_start();
      start_key = 1'b1; cyc(1);
      tests++; if (game_state !== 2'd1) begin fails++; $display("FAIL start_state got %0d exp 1", game_state); end
      tests++; if (move_en !== 1'b1) begin fails++; $display("FAIL start_move_en got %b exp 1", move_en); end
      tests++; if (lives !== 2'd3) begin fails++; $display("FAIL start_lives got %0d exp 3", lives); end
      tests++; if (time_left !== 7'd60) begin fails++; $display("FAIL start_time got %0d exp 60", time_left); end
      tests++; if (score_bcd !== 12'h000) begin fails++; $display("FAIL start_score got %h exp 000", score_bcd); end
      // held key: a start edge in PLAY must be ignored too
      cyc(3); start_key = 1'b0; cyc(1);
      pulse_start();
      tests++; if (game_state !== 2'd1) begin fails++; $display("FAIL start_ignored_in_play got %0d exp 1", game_state); end
   endtask

   task automatic test_score_carry();
      for (int i = 0; i < 99; i++) pulse_dragon();
      tests++; if (score_bcd !== 12'h099) begin fails++; $display("FAIL score_99 got %h exp 099", score_bcd); end
      pulse_dragon();
      tests++; if (score_bcd !== 12'h100) begin fails++; $display("FAIL score_carry got %h exp 100", score_bcd); end
      tests++; if (game_state !== 2'd1) begin fails++; $display("FAIL score_state got %0d exp 1", game_state); end
   endtask

   task automatic test_dragon_hold();
      hit_dragon = 1'b1; cyc(10); hit_dragon = 1'b0; cyc(1);
      tests++; if (score_bcd !== 12'h101) begin fails++; $display("FAIL held_dragon got %h exp 101", score_bcd); end
   endtask

   task automatic test_robot_hit(input logic [1:0] exp_lives);
      hit_robot = 1'b1; cyc(1); hit_robot = 1'b0;
      tests++; if (game_state !== 2'd2) begin fails++; $display("FAIL hit_state got %0d exp 2", game_state); end
      tests++; if (lives !== exp_lives) begin fails++; $display("FAIL hit_lives got %0d exp %0d", lives, exp_lives); end
      tests++; if (move_en !== 1'b0) begin fails++; $display("FAIL hit_move_en got %b exp 0", move_en); end
      cyc(1);
      pulse_dragon();
      tests++; if (score_bcd !== 12'h101) begin fails++; $display("FAIL hit_dragon_ignored got %h exp 101", score_bcd); end
      pulse_tick();
      tests++; if (game_state !== 2'd2) begin fails++; $display("FAIL hit_after_tick1 got %0d exp 2", game_state); end
      tests++; if (time_left !== 7'd60) begin fails++; $display("FAIL hit_time_paused got %0d exp 60", time_left); end
      tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
      tests++; if (game_state !== 2'd1) begin fails++; $display("FAIL hit_release got %0d exp 1", game_state); end
      tests++; if (move_en !== 1'b1) begin fails++; $display("FAIL hit_release_move_en got %b exp 1", move_en); end
      tests++; if (time_left !== 7'd60) begin fails++; $display("FAIL hit_release_time got %0d exp 60", time_left); end
      cyc(1);
   endtask

   task automatic test_simultaneous_lose();
      hit_robot = 1'b1; hit_dragon = 1'b1; tick_1hz = 1'b1; cyc(1);
      hit_robot = 1'b0; hit_dragon = 1'b0; tick_1hz = 1'b0;
      tests++; if (score_bcd !== 12'h102) begin fails++; $display("FAIL simul_score got %h exp 102", score_bcd); end
      tests++; if (time_left !== 7'd59) begin fails++; $display("FAIL simul_time got %0d exp 59", time_left); end
      tests++; if (lives !== 2'd0) begin fails++; $display("FAIL simul_lives got %0d exp 0", lives); end
      tests++; if ({game_state, win, move_en} !== 4'b11_0_0) begin fails++; $display("FAIL simul_over state=%0d win=%b move_en=%b exp 3/0/0", game_state, win, move_en); end
      cyc(1);
      pulse_tick(); pulse_dragon();
      tests++; if ({score_bcd, time_left} !== {12'h102, 7'd59}) begin fails++; $display("FAIL over_frozen score=%h time=%0d exp 102/59", score_bcd, time_left); end
   endtask

   task automatic test_timeout();
      pulse_start();
      tests++; if ({game_state, score_bcd} !== {2'd0, 12'h102}) begin fails++; $display("FAIL over_to_idle state=%0d score=%h exp 0/102", game_state, score_bcd); end
      pulse_start();
      tests++; if ({game_state, lives, time_left, score_bcd} !== {2'd1, 2'd3, 7'd60, 12'h000}) begin fails++; $display("FAIL restart state=%0d lives=%0d time=%0d score=%h exp 1/3/60/000", game_state, lives, time_left, score_bcd); end
      for (int i = 0; i < 59; i++) pulse_tick();
      tests++; if ({game_state, time_left} !== {2'd1, 7'd1}) begin fails++; $display("FAIL tick59 state=%0d time=%0d exp 1/1", game_state, time_left); end
      pulse_tick();
      tests++; if ({game_state, time_left, win, move_en} !== {2'd3, 7'd0, 1'b1, 1'b0}) begin fails++; $display("FAIL timeout state=%0d time=%0d win=%b move_en=%b exp 3/0/1/0", game_state, time_left, win, move_en); end
      pulse_start();
      tests++; if (game_state !== 2'd0) begin fails++; $display("FAIL timeout_to_idle got %0d exp 0", game_state); end
      pulse_start();
      tests++; if ({score_bcd, lives, win} !== {12'h000, 2'd3, 1'b0}) begin fails++; $display("FAIL timeout_restart score=%h lives=%0d win=%b exp 000/3/0", score_bcd, lives, win); end
   endtask

   task automatic test_win_score();
      for (int i = 0; i < 199; i++) pulse_dragon();
      tests++; if ({game_state, score_bcd} !== {2'd1, 12'h199}) begin fails++; $display("FAIL pre_win state=%0d score=%h exp 1/199", game_state, score_bcd); end
      // robot hit that leaves lives coincides with the winning point
      hit_robot = 1'b1; hit_dragon = 1'b1; cyc(1); hit_robot = 1'b0; hit_dragon = 1'b0;
      tests++; if ({game_state, win, lives, score_bcd} !== {2'd3, 1'b1, 2'd2, 12'h200}) begin fails++; $display("FAIL win_score state=%0d win=%b lives=%0d score=%h exp 3/1/2/200", game_state, win, lives, score_bcd); end
      cyc(1);
      pulse_start();
   endtask

   task automatic test_reset_in_hit();
      pulse_start();
      hit_robot = 1'b1; cyc(1); hit_robot = 1'b0; cyc(1);
      pulse_tick();
      tests++; if (game_state !== 2'd2) begin fails++; $display("FAIL pre_reset_hit got %0d exp 2", game_state); end
      rst = 1'b0; #2;
      tests++; if ({game_state, move_en, score_bcd, lives, time_left, win} !== 25'd0) begin fails++; $display("FAIL async_reset state=%0d move_en=%b score=%h lives=%0d time=%0d win=%b exp all 0", game_state, move_en, score_bcd, lives, time_left, win); end
      cyc(2); rst = 1'b1; cyc(1);
      pulse_tick(); pulse_tick(); pulse_tick();
      tests++; if ({game_state, time_left} !== {2'd0, 7'd0}) begin fails++; $display("FAIL post_reset_ticks state=%0d time=%0d exp 0/0", game_state, time_left); end
      pulse_start();
      tests++; if ({game_state, lives, time_left} !== {2'd1, 2'd3, 7'd60}) begin fails++; $display("FAIL post_reset_start state=%0d lives=%0d time=%0d exp 1/3/60", game_state, lives, time_left); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_score_carry();
      test_dragon_hold();
      test_robot_hit(2'd2);
      test_robot_hit(2'd1);
      test_simultaneous_lose();
      test_timeout();
      test_win_score();
      test_reset_in_hit();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
